// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
//   Shared definitions for the MAR/MDR memory interface:
//     - default data/address widths
//     - access state encoding (IDLE, RD_WAIT, WR_WAIT, DONE)
//     - helper that tells whether a state accepts new register loads/requests
// -----------------------------------------------------------------------------
package mem_if_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // IDLE and DONE are the only states in which MAR/MDR may be loaded
    // from the bus and a new access may start.
    function automatic logic is_accepting(input state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/register_n.sv
// -----------------------------------------------------------------------------
// register_n
//   Generic WIDTH-bit register with asynchronous active-high clear and a
//   synchronous load enable. Used for both MAR and MDR.
// Ports
//   clock  in   1      clock, rising edge
//   clear  in   1      asynchronous clear to zero, active-high
//   en     in   1      load d on the next rising edge
//   d      in   WIDTH  data input
//   q      out  WIDTH  register contents
// -----------------------------------------------------------------------------
module register_n #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: clocked state is always written with non-blocking (<=) so every
    // register samples its inputs as they were before the edge.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_data_if.sv
// -----------------------------------------------------------------------------
// mem_data_if
//   Parametrised MAR/MDR pair between the internal bus and memory, with a
//   request/acknowledge handshake of variable latency. The control unit
//   strobes rd_req or wr_req and waits for the one-cycle done pulse.
//   MAR and MDR are locked while an access is in flight.
//
// Configuration
//   MEM_TIMEOUT_EN  when defined, an access waiting TIMEOUT_CYCLES cycles
//                   without mem_ack aborts to IDLE and sets the sticky err
//                   flag. When undefined, waits are unbounded and err is 0.
//
// Ports
//   clock      in   1           clock, all state on rising edge
//   clear      in   1           asynchronous active-high reset
//   BusMuxOut  in   DATA_WIDTH  internal bus value
//   MARin      in   1           load MAR from BusMuxOut[ADDR_WIDTH-1:0]
//   MDRin      in   1           load MDR from BusMuxOut
//   rd_req     in   1           start memory read (1-cycle strobe)
//   wr_req     in   1           start memory write of MDR (1-cycle strobe)
//   MDRout     out  DATA_WIDTH  MDR contents
//   mem_addr   out  ADDR_WIDTH  MAR contents
//   mem_wdata  out  DATA_WIDTH  MDR contents
//   mem_rd     out  1           read request, held until mem_ack
//   mem_wr     out  1           write request, held until mem_ack
//   mem_rdata  in   DATA_WIDTH  read data, valid with mem_ack during a read
//   mem_ack    in   1           memory acknowledge
//   busy       out  1           access in flight
//   done       out  1           one-cycle pulse when an access completes
//   err        out  1           sticky timeout flag
// -----------------------------------------------------------------------------
module mem_data_if
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  rd_req,
    input  logic                  wr_req,
    output logic [DATA_WIDTH-1:0] MDRout,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_data_if: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    state_t state_next;

    logic accepting;
    logic req_taken;
    logic waiting;
    logic rd_complete;
    logic timeout;

    logic                  mar_en;
    logic                  mdr_en;
    logic [DATA_WIDTH-1:0] mdr_d;

    assign accepting   = is_accepting(state);
    assign req_taken   = accepting && (rd_req || wr_req);
    assign waiting     = (state == RD_WAIT) || (state == WR_WAIT);
    assign rd_complete = (state == RD_WAIT) && mem_ack;

    // -------------------------------------------------------------------------
    // Access FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                // Read wins when both strobes arrive together.
                if (rd_req) begin
                    state_next = RD_WAIT;
                end else if (wr_req) begin
                    state_next = WR_WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // An ack in the terminal cycle takes priority over timeout.
                if (mem_ack) begin
                    state_next = DONE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the registered state, so clear drops them immediately.
    assign mem_rd = (state == RD_WAIT);
    assign mem_wr = (state == WR_WAIT);
    assign busy   = waiting;
    assign done   = (state == DONE);

    // -------------------------------------------------------------------------
    // Optional timeout
    // -------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // The counter holds the number of ack-less wait cycles already elapsed,
    // so the abort fires during the TIMEOUT_CYCLES-th such cycle.
    assign timeout = waiting && !mem_ack
                     && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (req_taken) begin
                wait_cnt <= '0;
                err_q    <= 1'b0;
            end else if (timeout) begin
                err_q    <= 1'b1;
            end else if (waiting && !mem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // MAR / MDR
    // -------------------------------------------------------------------------
    // Bus loads are honoured only in IDLE/DONE; an MDRin in the same cycle as
    // rd_req loads the bus value first and the read overwrites it on ack.
    assign mar_en = accepting && MARin;
    assign mdr_en = rd_complete || (accepting && MDRin);
    assign mdr_d  = rd_complete ? mem_rdata : BusMuxOut;

    register_n #(.WIDTH(ADDR_WIDTH)) u_mar (
        .clock (clock),
        .clear (clear),
        .en    (mar_en),
        .d     (BusMuxOut[ADDR_WIDTH-1:0]),
        .q     (mem_addr)
    );

    register_n #(.WIDTH(DATA_WIDTH)) u_mdr (
        .clock (clock),
        .clear (clear),
        .en    (mdr_en),
        .d     (mdr_d),
        .q     (MDRout)
    );

    assign mem_wdata = MDRout;

endmodule

// File: tb/tb_mem_data_if.sv
module tb_mem_data_if;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int TC = 4;

    logic          clock = 1'b0;
    logic          clear;
    logic [DW-1:0] BusMuxOut;
    logic          MARin;
    logic          MDRin;
    logic          rd_req;
    logic          wr_req;
    logic [DW-1:0] MDRout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          done;
    logic          err;

    mem_data_if #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .BusMuxOut (BusMuxOut),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .MDRout    (MDRout),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected MDR value per completing access, in order.
    logic [DW-1:0] exp_q[$];
    int            dones_expected = 0;
    int            dones_seen     = 0;

    always @(negedge clock) begin
        if (!clear && done) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                check("sb_mdr_on_done", MDRout, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_done(input logic [DW-1:0] v);
        exp_q.push_back(v);
        dones_expected++;
    endtask

    // Memory responder: acks after 'waits' wait cycles, checking the
    // handshake and the locked address/data every cycle of the access.
    task automatic respond(input logic is_rd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int waits);
        for (int w = 0; w <= waits; w++) begin
            check("strobe_high",  is_rd ? {31'd0, mem_rd} : {31'd0, mem_wr}, 32'd1);
            check("other_strobe", is_rd ? {31'd0, mem_wr} : {31'd0, mem_rd}, 32'd0);
            check("busy_in_wait", {31'd0, busy}, 32'd1);
            check("mem_addr",     {23'd0, mem_addr}, {23'd0, addr});
            if (!is_rd) check("mem_wdata", mem_wdata, data);
            if (w == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = is_rd ? data : $urandom;
            end else begin
                mem_rdata = $urandom;
            end
            step();
            mem_ack = 1'b0;
        end
        check("done_pulse",     {31'd0, done}, 32'd1);
        check("strobe_dropped", {31'd0, mem_rd | mem_wr}, 32'd0);
        check("mdr_after",      MDRout, data);
    endtask

    typedef struct {
        logic          is_rd;
        logic [DW-1:0] bus_addr;
        logic [DW-1:0] data;
        int            waits;
    } vec_t;

    vec_t          vecs[6];
    logic [AW-1:0] a;
    logic [DW-1:0] last_mdr;
    int            cnt;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 0};
        vecs[1] = '{1'b0, 32'h0000_01FF, 32'h1234_5678, 3};
        vecs[2] = '{1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 2};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 0};
        vecs[4] = '{1'b1, 32'hABCD_E0AB, 32'hFFFF_FFFF, 1};  // high bus bits dropped
        vecs[5] = '{1'b0, 32'h0000_0155, 32'h8000_0000, 5};

        clear = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0;
        rd_req = 0; wr_req = 0; mem_rdata = '0; mem_ack = 0;
        #12;
        check("rst_mdr",  MDRout, 32'd0);
        check("rst_mar",  {23'd0, mem_addr}, 32'd0);
        check("rst_ctrl", {27'd0, mem_rd, mem_wr, busy, done, err}, 32'd0);
        step();
        clear = 1'b0;
        step();

        // ---------------- table-driven accesses ----------------
        for (int i = 0; i < 6; i++) begin
            a = vecs[i].bus_addr[AW-1:0];
            BusMuxOut = vecs[i].bus_addr; MARin = 1'b1;
            step();
            MARin = 1'b0;
            if (!vecs[i].is_rd) begin
                BusMuxOut = vecs[i].data; MDRin = 1'b1;
                step();
                MDRin = 1'b0;
            end
            BusMuxOut = 32'h0BAD_0BAD;
            if (vecs[i].is_rd) rd_req = 1'b1; else wr_req = 1'b1;
            expect_done(vecs[i].data);
            step();
            rd_req = 1'b0; wr_req = 1'b0;
            respond(vecs[i].is_rd, a, vecs[i].data, vecs[i].waits);
            check("err_clear", {31'd0, err}, 32'd0);
        end
        last_mdr = 32'h8000_0000;

        // ---------------- busy lock ----------------
        BusMuxOut = 32'h0000_0033; MARin = 1'b1;
        step();
        MARin = 1'b0; rd_req = 1'b1;
        expect_done(32'h600D_F00D);
        step();
        rd_req = 1'b0;
        BusMuxOut = 32'hFFFF_0000; MDRin = 1'b1; MARin = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        step();
        MDRin = 1'b0; MARin = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        check("lock_mar", {23'd0, mem_addr}, 32'h0000_0033);
        check("lock_mdr", MDRout, last_mdr);
        respond(1'b1, 9'h033, 32'h600D_F00D, 0);
        step();
        check("no_second_access", {30'd0, mem_rd, mem_wr}, 32'd0);

        // ---------------- read/write priority ----------------
        BusMuxOut = 32'h0000_00AA; MARin = 1'b1;
        step();
        MARin = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        expect_done(32'h1357_9BDF);
        step();
        rd_req = 1'b0; wr_req = 1'b0;
        respond(1'b1, 9'h0AA, 32'h1357_9BDF, 2);

        // ---------------- MDRin together with rd_req ----------------
        BusMuxOut = 32'h1111_2222; MDRin = 1'b1; rd_req = 1'b1;
        expect_done(32'hCAFE_0001);
        step();
        MDRin = 1'b0; rd_req = 1'b0;
        check("same_cycle_mdrin", MDRout, 32'h1111_2222);
        respond(1'b1, 9'h0AA, 32'hCAFE_0001, 1);

        // ---------------- ack while idle is ignored ----------------
        step();
        mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
        step();
        mem_ack = 1'b0;
        check("idle_ack_mdr",  MDRout, 32'hCAFE_0001);
        check("idle_ack_busy", {31'd0, busy}, 32'd0);

        // ---------------- stalled read ----------------
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd) cnt++;
            mem_rdata = $urandom;
            step();
        end
        check("timeout_wait_cycles", cnt, TC);
        check("timeout_err",  {31'd0, err}, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_mdr",  MDRout, 32'hCAFE_0001);
        rd_req = 1'b1;
        expect_done(32'h0F0F_0F0F);
        step();
        rd_req = 1'b0;
        check("err_cleared_by_req", {31'd0, err}, 32'd0);
        respond(1'b1, 9'h0AA, 32'h0F0F_0F0F, 0);
`else
        for (int i = 0; i < 20; i++) begin
            mem_rdata = $urandom;
            step();
        end
        check("stall_still_rd", {31'd0, mem_rd}, 32'd1);
        check("stall_err",      {31'd0, err}, 32'd0);
        check("stall_mdr",      MDRout, 32'hCAFE_0001);
        expect_done(32'h0F0F_0F0F);
        respond(1'b1, 9'h0AA, 32'h0F0F_0F0F, 0);
`endif

        // ---------------- clear in the middle of a read ----------------
        BusMuxOut = 32'h0000_0044; MARin = 1'b1;
        step();
        MARin = 1'b0; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("pre_abort_rd", {31'd0, mem_rd}, 32'd1);
        clear = 1'b1;
        #1;
        check("abort_ctrl", {27'd0, mem_rd, mem_wr, busy, done, err}, 32'd0);
        check("abort_mdr",  MDRout, 32'd0);
        check("abort_mar",  {23'd0, mem_addr}, 32'd0);
        step();
        clear = 1'b0;
        step();
        step();
        check("post_abort_idle", {29'd0, mem_rd, busy, done}, 32'd0);

        check("done_count",  dones_seen, dones_expected);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
